// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, start-glitch rejection,
// framing-error detection with break hold-off. Outputs mirror uart_tx's data/data_ready pair.
module uart_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    r_sync;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_data_ready;
    logic          r_frame_err;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    logic [7:0]    w_shift_next;
    logic [7:0]    w_data_next;
    logic          w_data_ready_next;
    logic          w_frame_err_next;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], serial};
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_shift      <= w_shift_next;
            r_data       <= w_data_next;
            r_data_ready <= w_data_ready_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_idx_next        = r_idx;
        w_shift_next      = r_shift;
        w_data_next       = r_data;
        w_data_ready_next = 1'b0;
        w_frame_err_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A start bit that is gone by mid-bit was noise, not a frame.
                if (r_cnt == HALF_M1) begin
                    w_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_idx_next   = '0;
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_shift_next[r_idx] = w_rx_s;
                    w_cnt_next          = '0;
                    w_idx_next          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next       = r_shift;
                        w_data_ready_next = 1'b1;
                        w_state_next      = S_IDLE;
                    end else begin
                        w_frame_err_next  = 1'b1;
                        w_state_next      = S_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a long break reports once.
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign data       = r_data;
    assign data_ready = r_data_ready;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule
